// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory responder: FSM states, error codes
// and the word-index width helper.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2
    } err_e;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/imem_store.sv
// Instruction store: DEPTH_WORDS x DATA_W array, synchronous write, combinational read.
// Contents are deliberately not reset.
module imem_store #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: wait-state instruction store behind a valid/ready handshake.
// Optional one-entry last-fetch bypass is enabled by defining IMEM_LAST_HIT_EN.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int unsigned IDX_W   = idx_width(DEPTH_WORDS);
    localparam logic [3:0]  WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    function automatic err_e addr_check(input logic [ADDR_W-1:0] a);
        if (a[1:0] != 2'b00) return ERR_MISALIGN;
        if ((a >> (IDX_W + 2)) != '0) return ERR_RANGE;
        return ERR_NONE;
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic              accept, load, hit, wr_in_range;
    logic [ADDR_W-1:0] rd_addr;
    err_e              rd_code;
    logic [DATA_W-1:0] rd_data, load_data;

    assign req_ready   = rst && (state_q == IDLE) && !flush;
    assign accept      = req_valid && req_ready;
    // In IDLE the read port looks at the incoming request so the zero-wait/hit path needs no extra cycle.
    assign rd_addr     = (state_q == IDLE) ? req_addr : addr_q;
    assign rd_code     = addr_check(rd_addr);
    assign wr_in_range = (wr_addr >> (IDX_W + 2)) == '0;

    imem_store #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_store (
        .clk_i     (clk),
        .wr_en_i   (wr_en && wr_in_range),
        .wr_idx_i  (wr_addr[IDX_W+1:2]),
        .wr_data_i (wr_data),
        .rd_idx_i  (rd_addr[IDX_W+1:2]),
        .rd_data_o (rd_data)
    );

`ifdef IMEM_LAST_HIT_EN
    logic              hit_valid_q, hit_valid_d;
    logic [ADDR_W-1:0] hit_addr_q, hit_addr_d;
    logic [DATA_W-1:0] hit_data_q, hit_data_d;

    assign hit       = (state_q == IDLE) && hit_valid_q && (req_addr == hit_addr_q);
    assign load_data = (rd_code != ERR_NONE) ? '0 : (hit ? hit_data_q : rd_data);

    // A write landing on the word being captured this cycle must still invalidate it.
    always_comb begin
        hit_valid_d = hit_valid_q;
        hit_addr_d  = hit_addr_q;
        hit_data_d  = hit_data_q;
        if (load && !flush && (rd_code == ERR_NONE)) begin
            hit_valid_d = 1'b1;
            hit_addr_d  = rd_addr;
            hit_data_d  = load_data;
        end
        if (wr_en && (wr_addr[ADDR_W-1:2] == hit_addr_d[ADDR_W-1:2])) begin
            hit_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_valid_q <= 1'b0;
            hit_addr_q  <= '0;
            hit_data_q  <= '0;
        end else begin
            hit_valid_q <= hit_valid_d;
            hit_addr_q  <= hit_addr_d;
            hit_data_q  <= hit_data_d;
        end
    end
`else
    assign hit       = 1'b0;
    assign load_data = (rd_code != ERR_NONE) ? '0 : rd_data;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = req_addr;
                    cnt_d  = '0;
                    if ((WAIT_STATES == 0) || hit) begin
                        state_d = RESP;
                        load    = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == WS_LAST) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            data_d = load_data;
            err_d  = (rd_code != ERR_NONE);
        end
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = data_q;
    assign rsp_addr  = addr_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: driver pushes expected responses, a monitor
// checks latency, stability and contents whenever rsp_valid is presented.
module tb_imem_responder;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WS    = 2;

    logic          clk = 1'b0, rst = 1'b0;
    logic          req_valid = 1'b0, flush = 1'b0, rsp_ready = 1'b0, wr_en = 1'b0;
    logic [AW-1:0] req_addr = '0, wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          req_ready, rsp_valid, rsp_err;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;

    imem_responder #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
        longint        lat;
        longint        acc;
        bit            seen;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] mem_m [DEPTH];
    bit            hit_v = 0;
    logic [AW-1:0] hit_a = '0;
    longint        wr_cyc = -1;
    logic [AW-3:0] wr_word = '0;
    bit            rr_rand = 0;
    int            total = 0, bad = 0;

    function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", n, act, expv, $time);
        end
    endfunction

    function automatic bit is_err(input logic [AW-1:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    // Monitor: compares every presented response cycle against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
            end else begin
                if (!sbq[0].seen) begin
                    sbq[0].seen = 1;
                    chk("latency", cyc - sbq[0].acc + 1, sbq[0].lat);
`ifdef IMEM_LAST_HIT_EN
                    if (!sbq[0].err) begin
                        hit_a = sbq[0].addr;
                        hit_v = !(wr_cyc == cyc && wr_word == sbq[0].addr[AW-1:2]);
                    end
`endif
                end
                chk("rsp_addr", rsp_addr, sbq[0].addr);
                chk("rsp_data", rsp_data, sbq[0].data);
                chk("rsp_err", rsp_err, sbq[0].err);
                chk("req_ready_busy", req_ready, 0);
                if (rsp_ready && !flush) void'(sbq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rr_rand) rsp_ready = ($urandom % 3) != 0;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
        mem_m[(a / 4) % DEPTH] = d;
        wr_cyc  = cyc;
        wr_word = a[AW-1:2];
        if (hit_v && hit_a[AW-1:2] == a[AW-1:2]) hit_v = 0;
    endtask

    task automatic send(input logic [AW-1:0] a);
        exp_t e;
        int   n = 0;
        bit   done = 0;
        req_valid = 1; req_addr = a;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                e.addr = a;
                e.err  = is_err(a);
                e.data = e.err ? '0 : mem_m[(a / 4) % DEPTH];
                e.lat  = (hit_v && a == hit_a) ? 1 : WS + 1;
                e.acc  = cyc + 1;
                e.seen = 0;
                sbq.push_back(e);
                done = 1;
            end else if (++n > 50) begin
                chk("accept_timeout", {63'd0, req_ready}, 64'd1);
                done = 1;
            end
            tick();
        end
        req_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain", sbq.size(), 0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk("valid_timeout", {63'd0, rsp_valid}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int unsigned   r;

        repeat (3) tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        rst = 1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        tick();

        for (int unsigned i = 0; i < DEPTH; i++) write_word(AW'(i * 4), $urandom);

        // Basic fetch with fixed latency
        rsp_ready = 1;
        write_word(32'h4, 32'hE3A0_1005);
        send(32'h4);
        wait_idle();

        // Backpressure: response held stable while rsp_ready is low
        rsp_ready = 0;
        send(32'h8);
        wait_valid();
        repeat (5) tick();
        rsp_ready = 1;
        tick();
        send(32'hC);
        wait_idle();

        // Error responses
        rr_rand = 1;
        send(32'h6);
        wait_idle();
        send(32'h1000);
        wait_idle();
        send(32'hFFFF_FFFC);
        wait_idle();

        // Flush in WAIT, with a competing request
        rr_rand = 0; rsp_ready = 1;
        send(32'h10);
        flush = 1; req_valid = 1; req_addr = 32'h14;
        @(negedge clk);
        chk("flush_blocks_ready", req_ready, 0);
        tick();
        flush = 0; req_valid = 0;
        sbq.delete();
        @(negedge clk);
        chk("flush_wait_valid", rsp_valid, 0);
        chk("flush_wait_ready", req_ready, 1);
        repeat (4) tick();

        // Flush in RESP with rsp_ready high: flush wins
        rsp_ready = 0;
        send(32'h14);
        wait_valid();
        flush = 1; rsp_ready = 1;
        tick();
        flush = 0;
        sbq.delete();
        @(negedge clk);
        chk("flush_resp_valid", rsp_valid, 0);
        chk("flush_resp_ready", req_ready, 1);
        repeat (4) tick();

        // Asynchronous reset mid-WAIT
        send(32'h4);
        tick();
        #2 rst = 0;
        #1;
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_req_ready", req_ready, 0);
        chk("arst_rsp_data", rsp_data, 0);
        chk("arst_rsp_addr", rsp_addr, 0);
        chk("arst_rsp_err", rsp_err, 0);
        sbq.delete();
        hit_v = 0;
        @(negedge clk);
        rst = 1;
        tick();
        send(32'h4);
        wait_idle();

        // Write to the word on the same edge it is read: old data returned, then new
        send(32'h28);
        repeat (WS - 1) tick();
        write_word(32'h28, 32'h1234_5678 ^ mem_m[10]);
        wait_idle();
        send(32'h28);
        wait_idle();

        // Repeated fetch, then rewrite of that word
        send(32'h8);
        wait_idle();
        send(32'h8);
        wait_idle();
        write_word(32'h8, 32'hCAFE_0008);
        send(32'h8);
        wait_idle();

        // Randomized traffic
        rr_rand = 1;
        for (int unsigned k = 0; k < 150; k++) begin
            r = $urandom % 8;
            if (r == 0) begin
                a = AW'(($urandom % 8) * 4);
                d = $urandom;
                write_word(a, d);
            end else if (r == 1) begin
                a = $urandom;
                send(a);
                wait_idle();
            end else begin
                a = (r < 5) ? AW'(($urandom % 8) * 4) : AW'(($urandom % DEPTH) * 4);
                send(a);
                wait_idle();
            end
        end

        rr_rand = 0; rsp_ready = 1;
        wait_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
